// File: rtl/audio_mixer_seq.sv
// Time-multiplexed stereo mixer: NCH unsigned channels with per-channel pan/volume,
// CPU index/data control port, saturating output and one delta-sigma DAC per side.
module audio_mixer_seq #(
  parameter int unsigned NCH        = 8,
  parameter int unsigned SW         = 8,
  parameter int unsigned DACW       = 10,
  parameter int unsigned OSH        = 1,
  parameter logic [7:0]  PORT_INDEX = 8'hF6,
  parameter logic [7:0]  PORT_DATA  = 8'hF7
) (
  input  logic                clk,
  input  logic                mrst_n,
  input  logic [7:0]          a,
  input  logic                iorq_n,
  input  logic                rd_n,
  input  logic                wr_n,
  input  logic [7:0]          din,
  output logic [7:0]          dout,
  output logic                oe,
  input  logic [NCH*SW-1:0]   ch_in,
  input  logic                sample_stb,
  output logic                busy,
  output logic                mix_valid,
  output logic [DACW-1:0]     mix_left,
  output logic [DACW-1:0]     mix_right,
  output logic                clip_left,
  output logic                clip_right,
  output logic                output_left,
  output logic                output_right
);

  localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned AW  = SW + KW + 1;
  localparam int unsigned SW2 = AW + DACW;
  localparam int unsigned SGW = DACW + 2;
  localparam logic [SGW-1:0] SIG_RST = {2'b01, {DACW{1'b0}}};
  localparam logic [SGW-1:0] SIG_FB  = {2'b11, {DACW{1'b0}}};
  localparam logic [SW2-1:0] SAT_MAX = SW2'({DACW{1'b1}});

  typedef enum logic [1:0] {IDLE, ACC, LOAD} state_t;
  state_t state, state_nxt;

  logic [7:0]      ctl [NCH];
  logic [7:0]      idx;
  logic            idx_ok, wr_idx, wr_dat;
  logic [SW-1:0]   samp  [NCH];
  logic [1:0]      pan_s [NCH];
  logic [4:0]      vol_s [NCH];
  logic [KW-1:0]   k;
  logic [AW-1:0]   acc_l, acc_r;
  logic [SW+3:0]   prod;
  logic [SW-1:0]   term;
  logic [SW2-1:0]  sh_l, sh_r;
  logic [SGW-1:0]  sig_l, sig_r;

  // CPU control port
  assign idx_ok = 32'(idx) < NCH;
  assign wr_idx = !iorq_n && !wr_n && (a == PORT_INDEX);
  assign wr_dat = !iorq_n && !wr_n && (a == PORT_DATA);

  always_ff @(posedge clk) begin
    if (!mrst_n) begin
      idx <= '0;
      for (int unsigned i = 0; i < NCH; i++) ctl[i] <= 8'hD0;
    end else begin
      if (wr_idx) idx <= din;
      if (wr_dat && idx_ok) ctl[idx[KW-1:0]] <= din;
    end
  end

  always_comb begin
    dout = '0;
    oe   = 1'b0;
    if (!iorq_n && !rd_n) begin
      if (a == PORT_INDEX) begin
        oe   = 1'b1;
        dout = idx;
      end else if (a == PORT_DATA) begin
        oe = 1'b1;
        if (idx_ok) dout = ctl[idx[KW-1:0]] & 8'hDF;
      end
    end
  end

  // FSM
  always_ff @(posedge clk) begin
    if (!mrst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_stb) state_nxt = ACC;
      ACC:     if (k == KW'(NCH - 1)) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath: the volume clamp is applied once at snapshot time
  assign prod = (SW+4)'(samp[k]) * (SW+4)'(vol_s[k]);
  assign term = SW'(prod >> 4);
  assign sh_l = SW2'(acc_l >> OSH);
  assign sh_r = SW2'(acc_r >> OSH);

  always_ff @(posedge clk) begin
    if (!mrst_n) begin
      k          <= '0;
      acc_l      <= '0;
      acc_r      <= '0;
      mix_left   <= '0;
      mix_right  <= '0;
      clip_left  <= 1'b0;
      clip_right <= 1'b0;
      mix_valid  <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      case (state)
        IDLE: if (sample_stb) begin
          for (int unsigned i = 0; i < NCH; i++) begin
            samp[i]  <= ch_in[i*SW +: SW];
            pan_s[i] <= ctl[i][7:6];
            vol_s[i] <= (ctl[i][4:0] > 5'd16) ? 5'd16 : ctl[i][4:0];
          end
          acc_l <= '0;
          acc_r <= '0;
          k     <= '0;
        end
        ACC: begin
          if (pan_s[k][1]) acc_l <= acc_l + AW'(term);
          if (pan_s[k][0]) acc_r <= acc_r + AW'(term);
          k <= k + 1'b1;
        end
        LOAD: begin
          mix_left   <= (sh_l > SAT_MAX) ? '1 : sh_l[DACW-1:0];
          mix_right  <= (sh_r > SAT_MAX) ? '1 : sh_r[DACW-1:0];
          clip_left  <= (sh_l > SAT_MAX);
          clip_right <= (sh_r > SAT_MAX);
          mix_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // First-order delta-sigma DACs
  always_ff @(posedge clk) begin
    if (!mrst_n) begin
      sig_l        <= SIG_RST;
      sig_r        <= SIG_RST;
      output_left  <= 1'b0;
      output_right <= 1'b0;
    end else begin
      output_left  <= sig_l[SGW-1];
      output_right <= sig_r[SGW-1];
      sig_l <= sig_l + SGW'(mix_left)  + (sig_l[SGW-1] ? SIG_FB : '0);
      sig_r <= sig_r + SGW'(mix_right) + (sig_r[SGW-1] ? SIG_FB : '0);
    end
  end

endmodule

// File: tb/tb_audio_mixer_seq.sv
// Randomized self-checking bench for audio_mixer_seq: two instances (OSH=1 and OSH=0)
// share stimulus and are compared with an arithmetic reference model.
module tb_audio_mixer_seq;
  localparam int NCH  = 8;
  localparam int SW   = 8;
  localparam int DACW = 10;
  localparam logic [7:0] P_IDX = 8'hF6;
  localparam logic [7:0] P_DAT = 8'hF7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic mrst_n, iorq_n, rd_n, wr_n, sample_stb;
  logic [7:0] a, din;
  logic [NCH*SW-1:0] ch_in;
  logic [7:0] dout, dout_s;
  logic oe, oe_s, busy, busy_s, mix_valid, mix_valid_s;
  logic [DACW-1:0] ml, mr, ml_s, mr_s;
  logic cl, cr, cl_s, cr_s, ol, orr, ol_s, or_s;

  audio_mixer_seq #(.NCH(NCH), .SW(SW), .DACW(DACW), .OSH(1)) u_dut (
    .clk(clk), .mrst_n(mrst_n), .a(a), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .din(din), .dout(dout), .oe(oe), .ch_in(ch_in), .sample_stb(sample_stb),
    .busy(busy), .mix_valid(mix_valid), .mix_left(ml), .mix_right(mr),
    .clip_left(cl), .clip_right(cr), .output_left(ol), .output_right(orr));

  audio_mixer_seq #(.NCH(NCH), .SW(SW), .DACW(DACW), .OSH(0)) u_sat (
    .clk(clk), .mrst_n(mrst_n), .a(a), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .din(din), .dout(dout_s), .oe(oe_s), .ch_in(ch_in), .sample_stb(sample_stb),
    .busy(busy_s), .mix_valid(mix_valid_s), .mix_left(ml_s), .mix_right(mr_s),
    .clip_left(cl_s), .clip_right(cr_s), .output_left(ol_s), .output_right(or_s));

  int n_chk = 0;
  int n_pass = 0;
  int samp [NCH];
  int m_ctl [NCH];
  int m_idx;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model: mix = min((sum of sample*min(v,16)/16 per side) >> osh, 2^DACW-1)
  function automatic void model_mix(input int osh, output int l, output int r,
                                    output int clp_l, output int clp_r);
    int sl = 0, sr = 0, v, t, lim;
    lim = (1 << DACW) - 1;
    for (int c = 0; c < NCH; c++) begin
      v = m_ctl[c] & 31;
      if (v > 16) v = 16;
      t = (samp[c] * v) / 16;
      if ((m_ctl[c] & 'h80) != 0) sl += t;
      if ((m_ctl[c] & 'h40) != 0) sr += t;
    end
    sl = sl >> osh;
    sr = sr >> osh;
    clp_l = (sl > lim) ? 1 : 0;
    clp_r = (sr > lim) ? 1 : 0;
    l = clp_l ? lim : sl;
    r = clp_r ? lim : sr;
  endfunction

  task automatic model_reset();
    m_idx = 0;
    for (int c = 0; c < NCH; c++) m_ctl[c] = 'hD0;
  endtask

  task automatic cpu_wr(input logic [7:0] addr, input logic [7:0] d);
    @(posedge clk); #1;
    a = addr; din = d; iorq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk); #1;
    iorq_n = 1'b1; wr_n = 1'b1;
    if (addr == P_IDX) m_idx = int'(d);
    else if (addr == P_DAT && m_idx < NCH) m_ctl[m_idx] = int'(d);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] addr);
    int exp_d, exp_oe;
    exp_oe = (addr == P_IDX || addr == P_DAT) ? 1 : 0;
    if (addr == P_IDX) exp_d = m_idx;
    else if (addr == P_DAT) exp_d = (m_idx < NCH) ? (m_ctl[m_idx] & 'hDF) : 0;
    else exp_d = 0;
    @(posedge clk); #2;
    a = addr; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
    chk({tag, ".dout"}, int'(dout), exp_d);
    chk({tag, ".oe"}, int'(oe), exp_oe);
    chk({tag, ".dout_s"}, int'(dout_s), exp_d);
    #1;
    iorq_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic drive_ch();
    for (int c = 0; c < NCH; c++) ch_in[c*SW +: SW] = SW'(samp[c]);
  endtask

  task automatic run_mix(input string tag, input bit extra_stb);
    int l0, r0, c0l, c0r, l1, r1, c1l, c1r, cyc, nbusy, nextra;
    model_mix(1, l0, r0, c0l, c0r);
    model_mix(0, l1, r1, c1l, c1r);
    drive_ch();
    @(posedge clk); #1;
    sample_stb = 1'b1;
    @(posedge clk); #1;
    sample_stb = 1'b0;
    // inputs changing after the strobe must not affect this mix
    for (int c = 0; c < NCH; c++) ch_in[c*SW +: SW] = SW'($urandom_range(0, 255));
    cyc = 1; nbusy = 0;
    while (mix_valid !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) nbusy++;
      sample_stb = (extra_stb && cyc == 3) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    sample_stb = 1'b0;
    chk({tag, ".latency"}, cyc, NCH + 2);
    chk({tag, ".busy_cycles"}, nbusy, NCH + 1);
    chk({tag, ".busy_end"}, int'(busy), 0);
    chk({tag, ".valid_s"}, int'(mix_valid_s), 1);
    chk({tag, ".left"}, int'(ml), l0);
    chk({tag, ".right"}, int'(mr), r0);
    chk({tag, ".clip_l"}, int'(cl), c0l);
    chk({tag, ".clip_r"}, int'(cr), c0r);
    chk({tag, ".left_s"}, int'(ml_s), l1);
    chk({tag, ".right_s"}, int'(mr_s), r1);
    chk({tag, ".clip_l_s"}, int'(cl_s), c1l);
    chk({tag, ".clip_r_s"}, int'(cr_s), c1r);
    nextra = 0;
    for (int i = 0; i < 3 * NCH; i++) begin
      @(posedge clk); #1;
      if (mix_valid === 1'b1 || mix_valid_s === 1'b1) nextra++;
    end
    chk({tag, ".no_extra_valid"}, nextra, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int i, cnt_l, cnt_r, cnt_ls, nv;
    int l0, r0, c0l, c0r, l1, r1, c1l, c1r;
    mrst_n = 1'b0; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    a = '0; din = '0; sample_stb = 1'b0; ch_in = '0;
    model_reset();
    for (int c = 0; c < NCH; c++) samp[c] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", int'(busy), 0);
    chk("rst.valid", int'(mix_valid), 0);
    chk("rst.left", int'(ml), 0);
    chk("rst.clip", int'(cl), 0);
    chk("rst.dac", int'(ol), 0);
    mrst_n = 1'b1;

    // Register access after reset
    cpu_wr(P_IDX, 8'd3);
    rd_chk("rst.ctl3", P_DAT);
    rd_chk("rst.idx", P_IDX);
    rd_chk("nonport", 8'h10);

    // Out-of-range index writes are dropped
    cpu_wr(P_IDX, 8'(NCH));
    cpu_wr(P_DAT, 8'h55);
    rd_chk("oor", P_DAT);
    for (int c = 0; c < NCH; c++) begin
      cpu_wr(P_IDX, 8'(c));
      rd_chk("oor.ctl", P_DAT);
    end

    // Default mix, full-scale inputs
    for (int c = 0; c < NCH; c++) samp[c] = 255;
    run_mix("dflt", 1'b0);

    // Pan and volume
    for (int c = 0; c < NCH; c++) begin
      cpu_wr(P_IDX, 8'(c));
      cpu_wr(P_DAT, (c == 0) ? 8'h88 : (c == 1) ? 8'h50 : 8'h00);
      samp[c] = $urandom_range(0, 255);
    end
    samp[0] = 200; samp[1] = 100;
    run_mix("panvol", 1'b0);
    cpu_wr(P_IDX, 8'd0);
    cpu_wr(P_DAT, 8'h9F);
    rd_chk("v31.rb", P_DAT);
    run_mix("v31", 1'b1);

    // Randomized register traffic and mixes
    for (int it = 0; it < 25; it++) begin
      for (int w = 0; w < 3; w++) begin
        i = ($urandom_range(0, 9) == 0) ? $urandom_range(NCH, 255) : $urandom_range(0, NCH - 1);
        cpu_wr(P_IDX, 8'(i));
        cpu_wr(P_DAT, 8'($urandom_range(0, 255)));
      end
      cpu_wr(P_IDX, 8'($urandom_range(0, NCH - 1)));
      rd_chk("rnd.rb", P_DAT);
      for (int c = 0; c < NCH; c++) samp[c] = $urandom_range(0, 255);
      run_mix("rnd", 1'($urandom_range(0, 1)));
    end

    // DAC density: left=256 (OSH=1), right muted, second instance left=512
    for (int c = 0; c < NCH; c++) begin
      cpu_wr(P_IDX, 8'(c));
      cpu_wr(P_DAT, (c < 3) ? 8'h90 : 8'h00);
      samp[c] = (c < 2) ? 255 : (c == 2) ? 2 : 0;
    end
    run_mix("dac", 1'b0);
    model_mix(1, l0, r0, c0l, c0r);
    model_mix(0, l1, r1, c1l, c1r);
    repeat (64) @(posedge clk);
    #1;
    cnt_l = 0; cnt_r = 0; cnt_ls = 0;
    for (int n = 0; n < (1 << DACW); n++) begin
      @(posedge clk); #1;
      cnt_l += int'(ol);
      cnt_r += int'(orr);
      cnt_ls += int'(ol_s);
    end
    chk("dac.ones_l", cnt_l, l0);
    chk("dac.ones_r", cnt_r, r0);
    chk("dac.ones_l_s", cnt_ls, l1);

    // Reset in the middle of accumulation
    @(posedge clk); #1;
    sample_stb = 1'b1;
    @(posedge clk); #1;
    sample_stb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid.busy_before", int'(busy), 1);
    mrst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid.busy", int'(busy), 0);
    chk("mid.left", int'(ml), 0);
    chk("mid.left_s", int'(ml_s), 0);
    chk("mid.valid", int'(mix_valid), 0);
    mrst_n = 1'b1;
    model_reset();
    nv = 0;
    for (int n = 0; n < 3 * NCH; n++) begin
      @(posedge clk); #1;
      if (mix_valid === 1'b1) nv++;
    end
    chk("mid.no_valid", nv, 0);
    rd_chk("mid.idx", P_IDX);
    rd_chk("mid.ctl0", P_DAT);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/audio_mixer_seq.md
# audio_mixer_seq

Parametrised, time-multiplexed stereo audio mixer with per-channel volume and pan, replacing the fixed-mix panner. Sits between the sound sources (PSGs, beeper, Specdrum, MIDI) and the board audio pins. Each sample period it accumulates NCH unsigned channels sequentially through one multiplier/adder pair, saturates to DACW bits and drives one first-order delta-sigma DAC per side. Control registers are reached by the CPU through an index/data I/O port pair.

## Interface
- NCH, 8: number of input channels (2..16)
- SW, 8: bits per channel sample, unsigned
- DACW, 10: DAC input width
- OSH, 1: right shift applied to the accumulator before saturation
- PORT_INDEX, 8'hF6: I/O address of the index register
- PORT_DATA, 8'hF7: I/O address of the data register
- clk  in  1  system clock; single clock domain
- mrst_n  in  1  reset, synchronous, active-low
- a  in  8  CPU address low byte
- iorq_n, rd_n, wr_n  in  1 each  CPU strobes, active-low
- din  in  8  CPU write data
- dout  out  8  CPU read data
- oe  out  1  dout valid for the current read cycle
- ch_in  in  NCH*SW  channel samples; channel k at [k*SW +: SW]
- sample_stb  in  1  one-cycle pulse that starts one mix
- busy  out  1  mix in progress
- mix_valid  out  1  one-cycle pulse when mix_left and mix_right update
- mix_left, mix_right  out  DACW  latest mixed sample, unsigned
- clip_left, clip_right  out  1  last sample saturated, per side
- output_left, output_right  out  1  delta-sigma bitstreams

## Operation
- Control register ctl[k], 8 bits per channel: [7:6] pan (00 mute, 10 left, 01 right, 11 both); [4:0] volume v, where values >16 act as 16; [5] reserved, reads 0. Reset value is 8'hD0 for every channel (both sides, unity gain).
- Index register idx, 8 bits, reset 0. Any write to PORT_INDEX loads idx = din. A write to PORT_DATA stores din into ctl[idx] only when idx < NCH; otherwise it is ignored. Writes take effect every cycle the strobes are active, so a repeated identical write is harmless.
- Reads are combinational: oe=1 iff iorq_n=0, rd_n=0 and a is PORT_INDEX or PORT_DATA. PORT_INDEX returns idx. PORT_DATA returns ctl[idx] with bit 5 cleared, or 8'h00 if idx >= NCH. When oe=0, dout=8'h00.
- FSM states are IDLE, ACC and LOAD.
  - IDLE: on sample_stb, snapshot ch_in and all ctl[], clear accL and accR, set k=0, then go to ACC.
  - ACC: term = (sample[k] * min(v,16)) >> 4, which is SW bits and 16 means unity. accL += term if pan[1]; accR += term if pan[0]. k++. After k = NCH-1, go to LOAD.
  - LOAD: s = acc >> OSH. The output is min(s, 2^DACW-1), and clip_x = (s > 2^DACW-1). Register mix_left, mix_right and the clip flags, pulse mix_valid, then return to IDLE.
- Accumulator width is SW + clog2(NCH) + 1. It never wraps.
- sample_stb while busy=1 is ignored and does not queue. CPU writes during a mix affect only the next sample.
- DAC, per side: first-order delta-sigma on a DACW-bit offset-binary input, with sigma register width DACW+2. On reset the sigma register is 1<<DACW and the output is 0. Each cycle, output <= sigma MSB, and sigma <= sigma + input + ({msb,msb} << DACW).
- Reset at any time, including mid-mix, forces IDLE, busy=0, and clears accumulators, mix_*, clip_* and mix_valid to 0. ctl[] and idx return to their reset values.

## Timing
- Cycle 0 is when sample_stb is sampled high in IDLE. busy=1 in cycles 1..NCH+1. ACC occupies cycles 1..NCH and LOAD occupies cycle NCH+1. mix_* and clip_* are visible and mix_valid=1 in cycle NCH+2, with busy=0 again.
- The earliest accepted next strobe is in cycle NCH+2. Minimum sample period is NCH+2 clocks.
- A register write is visible to a read on the following cycle and is used by the next sample_stb that arrives after the write cycle.
- DAC output lags a change in mix_x by one cycle. The density of 1s in the bitstream equals mix_x / 2^DACW.

## Test plan
- Reset values: after reset, write idx=3 and read PORT_DATA → 8'hD0. Read PORT_INDEX → 8'h03 with oe=1. In a non-port read, oe=0 and dout=00.
- Out-of-range index: with idx=NCH, write 8'h55 then read → 8'h00. All ctl[] remain unchanged.
- Default mix: every channel=8'hFF, defaults, sample_stb → mix_valid exactly 10 cycles later. mix_left=mix_right=1020, clip=0, and busy stays high for 9 cycles.
- Pan and volume: ch0=200 with ctl0=8'h88 (left, v=8); ch1=100 with ctl1=8'h50 (right, v=16); all other channels muted → mix_left=50, mix_right=50. Repeat with v=31 on ch0 → left=100.
- Saturation: OSH=0 build, all channels 8'hFF → mix=1023 and clip_left=clip_right=1. A second strobe asserted during busy is ignored, so only one mix_valid is seen.
- DAC and reset: hold mix_left=256 (DACW=10) → exactly 256 ones per 1024 cycles. Assert mrst_n=0 in mid-ACC → in the next cycle busy=0, mix=0, and no mix_valid follows.
